// File: rtl/filter_window_engine.sv
// 3x3 streaming convolution over an image in vector memory (identity/gaussian/sharpen/laplacian).
// Latency: read -> write 2 cycles; one band per img_w+1 cycles. No backpressure: memory is fixed-latency.
// FILTER_WINDOW_CLAMP_EN: saturate results to [0, 2^DATA_W-1]; otherwise keep the low DATA_W bits.
module filter_window_engine #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 19,
    parameter int DIM_W  = 10
) (
    input  logic              Clock,
    input  logic              RST,
    input  logic              start,
    input  logic [1:0]        kernel,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rd_data0,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int ACC_W = DATA_W + 6;
    localparam logic signed [ACC_W-1:0] PIX_MAX = $signed({{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}});

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_NEXT_ROW, S_DONE} state_t;

    state_t            state_q;
    logic [DIM_W-1:0]  w_q, h_q, col_q, row_q;
    logic [1:0]        kern_q;
    logic [ADDR_W-1:0] dst_row_q;
    logic              rd_en_q, busy_q, done_q, err_q;
    logic [ADDR_W-1:0] rd_addr0_q, rd_addr1_q, rd_addr2_q;

    // Read addresses simply increment: the last column of a row is followed by column 0 of the next.
    always_ff @(posedge Clock or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            kern_q     <= '0;
            dst_row_q  <= '0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_addr0_q <= '0;
            rd_addr1_q <= '0;
            rd_addr2_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= S_LOAD;
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                        w_q        <= img_w;
                        h_q        <= img_h;
                        kern_q     <= kernel;
                        rd_addr0_q <= src_base;
                        rd_addr1_q <= src_base + ADDR_W'(img_w);
                        rd_addr2_q <= src_base + ADDR_W'(img_w) + ADDR_W'(img_w);
                        dst_row_q  <= dst_base + ADDR_W'(img_w);
                    end
                end
                S_LOAD: begin
                    if (w_q < DIM_W'(3) || h_q < DIM_W'(3)) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        rd_en_q <= 1'b1;
                        col_q   <= '0;
                        row_q   <= DIM_W'(1);
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    rd_addr0_q <= rd_addr0_q + ADDR_W'(1);
                    rd_addr1_q <= rd_addr1_q + ADDR_W'(1);
                    rd_addr2_q <= rd_addr2_q + ADDR_W'(1);
                    if (col_q == w_q - DIM_W'(1)) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_NEXT_ROW;
                    end else begin
                        col_q <= col_q + DIM_W'(1);
                    end
                end
                S_NEXT_ROW: begin
                    if (row_q + DIM_W'(1) <= h_q - DIM_W'(2)) begin
                        row_q     <= row_q + DIM_W'(1);
                        dst_row_q <= dst_row_q + ADDR_W'(w_q);
                        col_q     <= '0;
                        rd_en_q   <= 1'b1;
                        state_q   <= S_RUN;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Error path arrives with done already set; normal path waits here for the last write to drain.
                    state_q <= S_IDLE;
                    if (done_q) begin
                        done_q <= 1'b0;
                    end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    function automatic logic signed [ACC_W-1:0] ext(input logic [DATA_W-1:0] p);
        return $signed({{(ACC_W-DATA_W){1'b0}}, p});
    endfunction

    logic                    vld_q, vld_d;
    logic [DIM_W-1:0]        vcol_q, vcol_d;
    logic [ADDR_W-1:0]       vwa_q, vwa_d;
    logic [2:0][DATA_W-1:0]  lft_q, lft_d, mid_q, mid_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]       wr_data_q, wr_data_d;
    logic signed [ACC_W-1:0] acc;
    logic [DATA_W-1:0]       res;

    // Window columns: lft = c-2, mid = c-1, rd_data = c; index 0 is row r-1.
    always_comb begin
        acc = '0;
        case (kern_q)
            2'b00: acc = ext(mid_q[1]);
            2'b01: acc = (ext(lft_q[0]) + ext(lft_q[2]) + ext(rd_data0) + ext(rd_data2)
                         + ((ext(lft_q[1]) + ext(mid_q[0]) + ext(mid_q[2]) + ext(rd_data1)) <<< 1)
                         + (ext(mid_q[1]) <<< 2)) >>> 4;
            2'b10: acc = (ext(mid_q[1]) <<< 2) + ext(mid_q[1])
                         - ext(mid_q[0]) - ext(mid_q[2]) - ext(lft_q[1]) - ext(rd_data1);
            default: acc = (ext(mid_q[1]) <<< 3)
                         - (ext(lft_q[0]) + ext(lft_q[1]) + ext(lft_q[2]) + ext(mid_q[0])
                         + ext(mid_q[2]) + ext(rd_data0) + ext(rd_data1) + ext(rd_data2));
        endcase
`ifdef FILTER_WINDOW_CLAMP_EN
        if (acc < 0)            res = '0;
        else if (acc > PIX_MAX) res = '1;
        else                    res = DATA_W'(acc);
`else
        res = DATA_W'(acc);
`endif
    end

    always_comb begin
        vld_d     = rd_en_q;
        vcol_d    = col_q;
        vwa_d     = dst_row_q + ADDR_W'(col_q) - ADDR_W'(1);
        lft_d     = lft_q;
        mid_d     = mid_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (vld_q) begin
            lft_d = mid_q;
            mid_d = {rd_data2, rd_data1, rd_data0};
            if (vcol_q >= DIM_W'(2)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = vwa_q;
                wr_data_d = res;
            end
        end
    end

    always_ff @(posedge Clock or negedge RST) begin
        if (!RST) begin
            vld_q     <= 1'b0;
            vcol_q    <= '0;
            vwa_q     <= '0;
            lft_q     <= '0;
            mid_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            vld_q     <= vld_d;
            vcol_q    <= vcol_d;
            vwa_q     <= vwa_d;
            lft_q     <= lft_d;
            mid_q     <= mid_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign rd_en    = rd_en_q;
    assign rd_addr0 = rd_addr0_q;
    assign rd_addr1 = rd_addr1_q;
    assign rd_addr2 = rd_addr2_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule

// File: tb/tb_filter_window_engine.sv
// Directed bench for filter_window_engine: behavioural dual-port memory, write log, hand-computed results.
module tb_filter_window_engine;
    localparam int DW = 18;
    localparam int AW = 19;
    localparam int MW = 10;

    logic          Clock = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    kernel = '0;
    logic [AW-1:0] src_base = '0, dst_base = '0;
    logic [MW-1:0] img_w = '0, img_h = '0;
    logic          rd_en, wr_en, busy, done, err;
    logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, wr_addr;
    logic [DW-1:0] rd_data0 = '0, rd_data1 = '0, rd_data2 = '0;
    logic [DW-1:0] wr_data;

    filter_window_engine #(.DATA_W(DW), .ADDR_W(AW), .DIM_W(MW)) dut (
        .Clock(Clock), .RST(RST), .start(start), .kernel(kernel),
        .src_base(src_base), .dst_base(dst_base), .img_w(img_w), .img_h(img_h),
        .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    logic [DW-1:0] mem [0:2047];
    always @(posedge Clock) begin
        if (rd_en) begin
            rd_data0 <= mem[rd_addr0[10:0]];
            rd_data1 <= mem[rd_addr1[10:0]];
            rd_data2 <= mem[rd_addr2[10:0]];
        end
    end

    int            checks = 0, errors = 0;
    int            t0 = 0, nwr = 0, nrd = 0, ndone = 0, first_rd = -1, done_cyc = -1;
    logic          err_at_done = 1'b0, busy_at_done = 1'b1;
    logic [AW-1:0] wa [64];
    logic [DW-1:0] wd [64];
    int            wc [64];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        nwr = 0; nrd = 0; ndone = 0; first_rd = -1; done_cyc = -1;
    endtask

    // Advance to the next falling edge and record what the DUT is doing in that cycle.
    task automatic step();
        @(negedge Clock);
        if (wr_en && nwr < 64) begin
            wa[nwr] = wr_addr; wd[nwr] = wr_data; wc[nwr] = cyc - t0; nwr++;
        end
        if (rd_en) begin
            nrd++;
            if (first_rd < 0) first_rd = cyc - t0;
        end
        if (done) begin
            ndone++; done_cyc = cyc - t0; err_at_done = err; busy_at_done = busy;
        end
    endtask

    task automatic launch(input int w, input int h, input int k, input int src, input int dst);
        img_w = MW'(w); img_h = MW'(h); kernel = 2'(k);
        src_base = AW'(src); dst_base = AW'(dst);
        start = 1'b1;
        t0 = cyc;
        clear_log();
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (ndone == 0 && n < limit) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, 64'(ndone > 0), 64'd1);
        repeat (3) step();
    endtask

    initial begin
        logic [DW-1:0] exp3, exp4;
`ifdef FILTER_WINDOW_CLAMP_EN
        exp3 = 18'd0;
        exp4 = 18'd262143;
`else
        exp3 = 18'd261744;
        exp4 = 18'd262136;
`endif
        for (int i = 0; i < 2048; i++) mem[i] = '0;

        repeat (2) @(negedge Clock);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rd_addr0", 64'(rd_addr0), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        RST = 1'b1;
        step();

        // 3x3 flat image, identity
        for (int i = 0; i < 9; i++) mem[i] = 18'd10;
        launch(3, 3, 0, 0, 100);
        check("t1_busy_load", 64'(busy), 64'd1);
        wait_done("t1", 40);
        check("t1_nwr", 64'(nwr), 64'd1);
        check("t1_addr", 64'(wa[0]), 64'd104);
        check("t1_data", 64'(wd[0]), 64'd10);
        check("t1_wr_cycle", 64'(wc[0]), 64'd6);
        check("t1_first_rd", 64'(first_rd), 64'd2);
        check("t1_nrd", 64'(nrd), 64'd3);
        check("t1_done_cycle", 64'(done_cyc), 64'd7);
        check("t1_busy_at_done", 64'(busy_at_done), 64'd0);
        check("t1_err", 64'(err_at_done), 64'd0);

        // 5x4 ramp, gaussian; a start pulse while busy must be ignored
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++) mem[200 + r*5 + c] = DW'(r*5 + c);
        launch(5, 4, 1, 200, 300);
        repeat (3) step();
        start = 1'b1; kernel = 2'd3;
        step();
        start = 1'b0;
        wait_done("t2", 60);
        check("t2_nwr", 64'(nwr), 64'd6);
        check("t2_ndone", 64'(ndone), 64'd1);
        for (int i = 0; i < 6; i++) begin
            check("t2_addr", 64'(wa[i]), 64'(300 + (1 + i/3)*5 + 1 + i%3));
            check("t2_data", 64'(wd[i]), 64'((1 + i/3)*5 + 1 + i%3));
        end
        check("t2_last_wr_cycle", 64'(wc[5]), 64'd14);
        check("t2_done_cycle", 64'(done_cyc), 64'd15);

        // 3x3 sharpen, center 0, neighbours 100 -> -400
        for (int i = 0; i < 9; i++) mem[400 + i] = 18'd100;
        mem[404] = 18'd0;
        launch(3, 3, 2, 400, 500);
        wait_done("t3", 40);
        check("t3_nwr", 64'(nwr), 64'd1);
        check("t3_addr", 64'(wa[0]), 64'd504);
        check("t3_data", 64'(wd[0]), 64'(exp3));

        // 3x3 laplacian, center max, neighbours 0
        for (int i = 0; i < 9; i++) mem[450 + i] = 18'd0;
        mem[454] = 18'd262143;
        launch(3, 3, 3, 450, 550);
        wait_done("t4", 40);
        check("t4_nwr", 64'(nwr), 64'd1);
        check("t4_data", 64'(wd[0]), 64'(exp4));

        // Illegal width
        launch(2, 8, 0, 0, 100);
        wait_done("t5", 20);
        check("t5_done_cycle", 64'(done_cyc), 64'd2);
        check("t5_err_at_done", 64'(err_at_done), 64'd1);
        check("t5_busy_at_done", 64'(busy_at_done), 64'd0);
        check("t5_nrd", 64'(nrd), 64'd0);
        check("t5_nwr", 64'(nwr), 64'd0);
        check("t5_err_held", 64'(err), 64'd1);

        // 6x6 ramp, sharpen; reset in the second band, then a clean rerun
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) mem[600 + r*6 + c] = DW'(r*6 + c + 1);
        launch(6, 6, 2, 600, 700);
        check("t6_err_cleared", 64'(err), 64'd0);
        while (cyc - t0 < 11) step();
        check("t6_reading_before_rst", 64'(rd_en), 64'd1);
        RST = 1'b0;
        #1;
        check("t6_rst_rd_en", 64'(rd_en), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_rd_addr0", 64'(rd_addr0), 64'd0);
        check("t6_rst_wr_en", 64'(wr_en), 64'd0);
        repeat (2) step();
        RST = 1'b1;
        clear_log();
        repeat (4) step();
        check("t6_quiet_nrd", 64'(nrd), 64'd0);
        check("t6_quiet_nwr", 64'(nwr), 64'd0);
        launch(6, 6, 2, 600, 700);
        wait_done("t6", 80);
        check("t6_nwr", 64'(nwr), 64'd16);
        for (int i = 0; i < 16; i++) begin
            check("t6_addr", 64'(wa[i]), 64'(700 + (1 + i/4)*6 + 1 + i%4));
            check("t6_data", 64'(wd[i]), 64'((1 + i/4)*6 + 1 + i%4 + 1));
        end
        check("t6_done_cycle", 64'(done_cyc), 64'd31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
